// File: rtl/cache_fill_fsm_if.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm_if
// Bundles the lookup, LRU-array and main-memory signals that the miss-handling
// controller exchanges with its neighbours.
//   master : the fill controller (cache_fill_fsm)
//   slave  : the surrounding cache / memory environment
// Lookup side : miss_detected, hit, hit_way, miss_address
// LRU side    : block0_isLRU, block1_isLRU (in), set_enable, lru_writeEn,
//               lru_block (out)
// Memory side : mem_read_en, mem_address (out), mem_data_valid (in)
// Array side  : write_data_array, fill_way, fill_word, write_tag_array
// Status      : fsm_busy, fill_done
// -----------------------------------------------------------------------------
interface cache_fill_fsm_if;
  logic        miss_detected;
  logic        hit;
  logic        hit_way;
  logic [15:0] miss_address;
  logic        block0_isLRU;
  logic        block1_isLRU;
  logic        mem_data_valid;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] mem_address;
  logic        write_data_array;
  logic        fill_way;
  logic [2:0]  fill_word;
  logic        write_tag_array;
  logic [63:0] set_enable;
  logic        lru_writeEn;
  logic        lru_block;
  logic        fill_done;

  modport master (
    input  miss_detected, hit, hit_way, miss_address,
    input  block0_isLRU, block1_isLRU, mem_data_valid,
    output fsm_busy, mem_read_en, mem_address, write_data_array,
    output fill_way, fill_word, write_tag_array, set_enable,
    output lru_writeEn, lru_block, fill_done
  );

  modport slave (
    output miss_detected, hit, hit_way, miss_address,
    output block0_isLRU, block1_isLRU, mem_data_valid,
    input  fsm_busy, mem_read_en, mem_address, write_data_array,
    input  fill_way, fill_word, write_tag_array, set_enable,
    input  lru_writeEn, lru_block, fill_done
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
// Miss-handling controller for a 2-way, 64-set cache. On a miss it latches the
// address and victim way, streams an 8-word block from pipelined memory into
// the data array, then writes the tag and marks the filled way MRU. In IDLE a
// hit refreshes the LRU state combinationally.
//
// Ports:
//   clk  - system clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - cache_fill_fsm_if.master (lookup, LRU, memory and array signals)
//
// Parameters:
//   MEM_LATENCY     - read-beat to valid-beat latency of memory (>= 1); the
//                     controller tracks valids, so it only constrains legality
//   WORDS_PER_BLOCK - must be 8
//
// Configuration macro:
//   CRITICAL_WORD_FIRST_EN - when defined, the fill starts at the missed word
//                            (miss_address[3:1]) and wraps; otherwise the fill
//                            always runs words 0..7.
// -----------------------------------------------------------------------------
module cache_fill_fsm #(
  parameter int MEM_LATENCY     = 4,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  cache_fill_fsm_if.master bus
);

  // Elaboration guard against configurations the datapath is not built for.
  if (MEM_LATENCY < 1 || WORDS_PER_BLOCK != 8) begin : g_param_check
    $error("cache_fill_fsm: unsupported MEM_LATENCY or WORDS_PER_BLOCK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] words_c = 4'd8;
  localparam logic [3:0] last_c  = 4'd7;

  function automatic logic [63:0] onehot64(input logic [5:0] idx);
    onehot64 = 64'd1 << idx;
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [5:0]  tag_r;
  logic [5:0]  index_r;
  logic [2:0]  start_r;
  logic        victim_r;
  logic [3:0]  issue_cnt_r;
  logic [3:0]  recv_cnt_r;

  logic [2:0]  start_word_s;
  logic        victim_s;
  logic [2:0]  issue_word_s;
  logic [2:0]  recv_word_s;
  logic        unused_addr_s;

  logic        fsm_busy_s;
  logic        mem_read_en_s;
  logic [15:0] mem_address_s;
  logic        write_data_array_s;
  logic        fill_way_s;
  logic [2:0]  fill_word_s;
  logic        write_tag_array_s;
  logic [63:0] set_enable_s;
  logic        lru_writeEn_s;
  logic        lru_block_s;
  logic        fill_done_s;

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_word_s = bus.miss_address[3:1];
`else
  assign start_word_s = 3'd0;
`endif
  // The byte-within-word bit never selects anything.
  assign unused_addr_s = &{1'b0, bus.miss_address[3:0]};

  // An unwritten set shows equal isLRU bits; the array's answer there is way 0.
  assign victim_s     = bus.block1_isLRU & ~bus.block0_isLRU;
  // 3-bit sums wrap modulo 8, giving the critical-word-first rotation.
  assign issue_word_s = start_r + issue_cnt_r[2:0];
  assign recv_word_s  = start_r + recv_cnt_r[2:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Miss context capture and issue/receive beat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_r       <= 6'd0;
      index_r     <= 6'd0;
      start_r     <= 3'd0;
      victim_r    <= 1'b0;
      issue_cnt_r <= 4'd0;
      recv_cnt_r  <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.miss_detected) begin
            tag_r       <= bus.miss_address[15:10];
            index_r     <= bus.miss_address[9:4];
            start_r     <= start_word_s;
            victim_r    <= victim_s;
            issue_cnt_r <= 4'd0;
            recv_cnt_r  <= 4'd0;
          end else begin
            issue_cnt_r <= issue_cnt_r;
            recv_cnt_r  <= recv_cnt_r;
          end
        end
        FILL: begin
          if (issue_cnt_r != words_c) begin
            issue_cnt_r <= issue_cnt_r + 4'd1;
          end else begin
            issue_cnt_r <= issue_cnt_r;
          end
          if (bus.mem_data_valid && (recv_cnt_r != words_c)) begin
            recv_cnt_r <= recv_cnt_r + 4'd1;
          end else begin
            recv_cnt_r <= recv_cnt_r;
          end
        end
        default: begin
          issue_cnt_r <= issue_cnt_r;
          recv_cnt_r  <= recv_cnt_r;
        end
      endcase
    end
  end

  // Next-state logic; a miss wins over a simultaneous hit.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.miss_detected) begin
          state_next_s = FILL;
        end else begin
          state_next_s = IDLE;
        end
      end
      FILL: begin
        if (bus.mem_data_valid && (recv_cnt_r == last_c)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = FILL;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode per state.
  always_comb begin
    fsm_busy_s         = 1'b0;
    mem_read_en_s      = 1'b0;
    mem_address_s      = 16'd0;
    write_data_array_s = 1'b0;
    fill_way_s         = 1'b0;
    fill_word_s        = 3'd0;
    write_tag_array_s  = 1'b0;
    set_enable_s       = onehot64(bus.miss_address[9:4]);
    lru_writeEn_s      = 1'b0;
    lru_block_s        = 1'b0;
    fill_done_s        = 1'b0;
    case (state_r)
      IDLE: begin
        // Hit refresh is zero-latency; the LRU array captures it on the next edge.
        if (!rst && bus.hit && !bus.miss_detected) begin
          lru_writeEn_s = 1'b1;
          lru_block_s   = ~bus.hit_way;
        end else begin
          lru_writeEn_s = 1'b0;
          lru_block_s   = 1'b0;
        end
      end
      FILL: begin
        fsm_busy_s   = 1'b1;
        set_enable_s = onehot64(index_r);
        fill_way_s   = victim_r;
        if (issue_cnt_r != words_c) begin
          mem_read_en_s = 1'b1;
          mem_address_s = {tag_r, index_r, issue_word_s, 1'b0};
        end else begin
          mem_read_en_s = 1'b0;
          mem_address_s = 16'd0;
        end
        if (bus.mem_data_valid) begin
          write_data_array_s = 1'b1;
          fill_word_s        = recv_word_s;
        end else begin
          write_data_array_s = 1'b0;
          fill_word_s        = 3'd0;
        end
      end
      DONE: begin
        fsm_busy_s        = 1'b1;
        set_enable_s      = onehot64(index_r);
        fill_way_s        = victim_r;
        write_tag_array_s = 1'b1;
        lru_writeEn_s     = 1'b1;
        lru_block_s       = ~victim_r;
        fill_done_s       = 1'b1;
      end
      default: begin
        fsm_busy_s = 1'b0;
      end
    endcase
  end

  assign bus.fsm_busy         = fsm_busy_s;
  assign bus.mem_read_en      = mem_read_en_s;
  assign bus.mem_address      = mem_address_s;
  assign bus.write_data_array = write_data_array_s;
  assign bus.fill_way         = fill_way_s;
  assign bus.fill_word        = fill_word_s;
  assign bus.write_tag_array  = write_tag_array_s;
  assign bus.set_enable       = set_enable_s;
  assign bus.lru_writeEn      = lru_writeEn_s;
  assign bus.lru_block        = lru_block_s;
  assign bus.fill_done        = fill_done_s;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_fsm
// Self-checking bench for cache_fill_fsm: a pipelined memory model, a
// transaction-level reference model of the fill, an IDLE vector table,
// hand-written fill/reset sequences and a randomized phase.
// -----------------------------------------------------------------------------
module tb_cache_fill_fsm;
  localparam int L       = 4;
  localparam int CYC_MOD = 1024;

  logic clk;
  logic rst;
  cache_fill_fsm_if bus ();

  cache_fill_fsm #(.MEM_LATENCY(L), .WORDS_PER_BLOCK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Memory: a read issued in cycle c returns its valid in cycle c+L.
  bit due [CYC_MOD];
  bit stray_valid;

  // Reference model of the fill as a transaction.
  bit          m_fill;
  int          m_t0;
  int          m_recv;
  int          m_done_cyc;
  logic [11:0] m_base;
  logic [2:0]  m_start;
  logic        m_victim;

  // Last sampled DUT outputs.
  logic        o_busy, o_rd, o_wr, o_way, o_tag, o_lwe, o_lb, o_done;
  logic [15:0] o_addr;
  logic [2:0]  o_word;
  logic [63:0] o_se;

  typedef struct {
    logic        rst_in;
    logic        hit_in;
    logic        hit_way_in;
    logic        valid_in;
    logic [15:0] addr_in;
    logic        exp_lwe;
    logic        exp_lb;
    logic [5:0]  exp_idx;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [2:0] start_of(input logic [15:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
    return a[3:1];
`else
    return 3'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    bus.miss_detected = 1'b0;
    bus.hit           = 1'b0;
    bus.hit_way       = 1'b0;
    bus.block0_isLRU  = 1'b0;
    bus.block1_isLRU  = 1'b0;
    stray_valid       = 1'b0;
    rst               = 1'b0;
  endtask

  // One clock cycle: drive valid, predict, sample at negedge, compare, advance.
  task automatic tick();
    logic        v;
    logic        e_busy, e_rd, e_wr, e_way, e_tag, e_lwe, e_lb, e_done;
    logic [15:0] e_addr;
    logic [2:0]  e_word;
    logic [5:0]  e_idx;
    int          k;
    v = due[cyc % CYC_MOD] | stray_valid;
    due[cyc % CYC_MOD] = 1'b0;
    bus.mem_data_valid = v;

    e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_way = 1'b0; e_tag = 1'b0;
    e_lwe = 1'b0; e_lb = 1'b0; e_done = 1'b0; e_addr = 16'd0; e_word = 3'd0;
    e_idx = bus.miss_address[9:4];
    if (!m_fill) begin
      if (!rst && bus.hit && !bus.miss_detected) begin
        e_lwe = 1'b1;
        e_lb  = ~bus.hit_way;
      end
    end else begin
      e_busy = 1'b1;
      e_idx  = m_base[5:0];
      e_way  = m_victim;
      if (cyc == m_done_cyc) begin
        e_tag  = 1'b1;
        e_lwe  = 1'b1;
        e_lb   = ~m_victim;
        e_done = 1'b1;
      end else begin
        k = cyc - m_t0;
        if (k >= 1 && k <= 8) begin
          e_rd   = 1'b1;
          e_addr = {m_base, 3'((int'(m_start) + k - 1) % 8), 1'b0};
        end
        if (v) begin
          e_wr   = 1'b1;
          e_word = 3'((int'(m_start) + m_recv) % 8);
        end
      end
    end

    @(negedge clk);
    o_busy = bus.fsm_busy;         o_rd   = bus.mem_read_en;
    o_addr = bus.mem_address;      o_wr   = bus.write_data_array;
    o_way  = bus.fill_way;         o_word = bus.fill_word;
    o_tag  = bus.write_tag_array;  o_se   = bus.set_enable;
    o_lwe  = bus.lru_writeEn;      o_lb   = bus.lru_block;
    o_done = bus.fill_done;
    chk("fsm_busy",         64'(o_busy), 64'(e_busy));
    chk("mem_read_en",      64'(o_rd),   64'(e_rd));
    chk("mem_address",      64'(o_addr), 64'(e_addr));
    chk("write_data_array", 64'(o_wr),   64'(e_wr));
    chk("fill_way",         64'(o_way),  64'(e_way));
    chk("fill_word",        64'(o_word), 64'(e_word));
    chk("write_tag_array",  64'(o_tag),  64'(e_tag));
    chk("set_enable",       o_se,        64'd1 << e_idx);
    chk("lru_writeEn",      64'(o_lwe),  64'(e_lwe));
    chk("lru_block",        64'(o_lb),   64'(e_lb));
    chk("fill_done",        64'(o_done), 64'(e_done));
    if (o_rd === 1'b1) due[(cyc + L) % CYC_MOD] = 1'b1;

    if (rst) begin
      m_fill = 1'b0;
    end else if (!m_fill) begin
      if (bus.miss_detected) begin
        m_fill     = 1'b1;
        m_t0       = cyc;
        m_base     = bus.miss_address[15:4];
        m_start    = start_of(bus.miss_address);
        m_victim   = (bus.block0_isLRU == bus.block1_isLRU) ? 1'b0 : bus.block1_isLRU;
        m_recv     = 0;
        m_done_cyc = -1;
      end
    end else if (cyc == m_done_cyc) begin
      m_fill = 1'b0;
    end else if (v) begin
      m_recv++;
      if (m_recv == 8) m_done_cyc = cyc + 1;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issue one miss and follow it for 14 cycles, collecting what happened.
  task automatic run_fill(input logic [15:0] addr, input logic b0, input logic b1,
                          input bit noisy, output int n_wr, output int done_off,
                          output int first_wr_off, output logic [15:0] first_addr,
                          output logic [2:0] first_word, output logic done_lb,
                          output logic way_seen, output logic busy_end);
    bit got_addr;
    got_addr = 1'b0;
    n_wr = 0; done_off = -1; first_wr_off = -1; first_addr = 16'd0;
    first_word = 3'd0; done_lb = 1'b0; way_seen = 1'b0; busy_end = 1'b1;
    bus.miss_detected = 1'b1;
    bus.miss_address  = addr;
    bus.block0_isLRU  = b0;
    bus.block1_isLRU  = b1;
    bus.hit           = 1'b0;
    tick();
    bus.miss_detected = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (noisy) begin
        bus.miss_address  = 16'($urandom);
        bus.hit           = 1'($urandom);
        bus.hit_way       = 1'($urandom);
        bus.block0_isLRU  = 1'($urandom);
        bus.block1_isLRU  = 1'($urandom);
        bus.miss_detected = (i < 14) ? 1'($urandom) : 1'b0;
      end
      tick();
      if (o_wr === 1'b1) begin
        n_wr++;
        way_seen = o_way;
        if (first_wr_off < 0) begin
          first_wr_off = i;
          first_word   = o_word;
        end
      end
      if (o_rd === 1'b1 && !got_addr) begin
        got_addr   = 1'b1;
        first_addr = o_addr;
      end
      if (o_done === 1'b1) begin
        done_off = i;
        done_lb  = o_lb;
      end
      if (i == 14) busy_end = o_busy;
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_wr, done_off, first_wr_off, n;
    logic [15:0] first_addr;
    logic [2:0]  first_word;
    logic        done_lb, way_seen, busy_end;

    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 6'h23};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hFFF0, 1'b1, 1'b1, 6'h3F};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'h00};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0ABC, 1'b0, 1'b0, 6'h2B};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h5550, 1'b0, 1'b0, 6'h15};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h03F0, 1'b1, 1'b1, 6'h3F};

    idle_inputs();
    bus.miss_address   = 16'h0000;
    bus.mem_data_valid = 1'b0;
    m_fill = 1'b0; m_t0 = 0; m_recv = 0; m_done_cyc = -1;
    m_base = 12'd0; m_start = 3'd0; m_victim = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_strobes", 64'({o_rd, o_wr, o_tag, o_lwe, o_done}), 64'd0);

    // IDLE vector table: hit refresh, set decode, reset gating, stray valids.
    foreach (vecs[i]) begin
      rst              = vecs[i].rst_in;
      bus.hit          = vecs[i].hit_in;
      bus.hit_way      = vecs[i].hit_way_in;
      bus.miss_address = vecs[i].addr_in;
      stray_valid      = vecs[i].valid_in;
      tick();
      chk("vec_lru_writeEn", 64'(o_lwe), 64'(vecs[i].exp_lwe));
      chk("vec_lru_block",   64'(o_lb),  64'(vecs[i].exp_lb));
      chk("vec_set_enable",  o_se,       64'd1 << vecs[i].exp_idx);
      chk("vec_no_write",    64'(o_wr),  64'd0);
      chk("vec_idle",        64'(o_busy), 64'd0);
    end
    idle_inputs();

    // Cold miss at 0x1234: victim way 0, writes from cycle 1+L, DONE at 9+L.
    run_fill(16'h1234, 1'b0, 1'b0, 1'b0, n_wr, done_off, first_wr_off,
             first_addr, first_word, done_lb, way_seen, busy_end);
    chk("cold_writes",     64'(n_wr),         64'd8);
    chk("cold_first_wr",   64'(first_wr_off), 64'(1 + L));
    chk("cold_done_cycle", 64'(done_off),     64'(9 + L));
    chk("cold_first_addr", 64'(first_addr),   64'({12'h123, start_of(16'h1234), 1'b0}));
    chk("cold_way",        64'(way_seen),     64'd0);
    chk("cold_done_lru",   64'(done_lb),      64'd1);
    chk("cold_busy_end",   64'(busy_end),     64'd0);

    // Same set, new tag, way 1 is LRU; inputs toggle during the fill.
    run_fill(16'h5634, 1'b0, 1'b1, 1'b1, n_wr, done_off, first_wr_off,
             first_addr, first_word, done_lb, way_seen, busy_end);
    chk("way1_writes",     64'(n_wr),       64'd8);
    chk("way1_fill_way",   64'(way_seen),   64'd1);
    chk("way1_done_lru",   64'(done_lb),    64'd0);
    chk("way1_first_addr", 64'(first_addr), 64'({12'h563, start_of(16'h5634), 1'b0}));

    // Miss to word 5: wraps when critical word first is enabled.
    run_fill(16'h123A, 1'b1, 1'b0, 1'b0, n_wr, done_off, first_wr_off,
             first_addr, first_word, done_lb, way_seen, busy_end);
    chk("cwf_first_addr", 64'(first_addr), 64'({12'h123, start_of(16'h123A), 1'b0}));
    chk("cwf_first_word", 64'(first_word), 64'(start_of(16'h123A)));
    chk("cwf_done_cycle", 64'(done_off),   64'(9 + L));

    // Hit together with miss: fill starts, no LRU write in that cycle.
    bus.hit = 1'b1; bus.hit_way = 1'b0; bus.miss_detected = 1'b1;
    bus.miss_address = 16'h2220;
    tick();
    chk("hitmiss_no_lru", 64'(o_lwe), 64'd0);
    idle_inputs();
    tick();
    chk("hitmiss_busy", 64'(o_busy), 64'd1);
    for (int i = 0; i < 14; i++) tick();

    // Reset at cycle 6 of a fill; in-flight beats must be dropped.
    bus.miss_address  = 16'h789A;
    bus.miss_detected = 1'b1;
    tick();
    bus.miss_detected = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 7; i <= 12; i++) begin
      stray_valid = (i == 11);
      tick();
      if (o_wr !== 1'b0) n++;
      if (i == 7) begin
        chk("rst_fill_busy",    64'(o_busy), 64'd0);
        chk("rst_fill_strobes", 64'({o_rd, o_wr, o_tag, o_lwe, o_done, o_way, o_word}), 64'd0);
      end
    end
    stray_valid = 1'b0;
    chk("rst_stray_writes", 64'(n), 64'd0);
    run_fill(16'h4440, 1'b0, 1'b0, 1'b0, n_wr, done_off, first_wr_off,
             first_addr, first_word, done_lb, way_seen, busy_end);
    chk("post_rst_writes", 64'(n_wr),     64'd8);
    chk("post_rst_done",   64'(done_off), 64'(9 + L));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2500; i++) begin
      rst               = ($urandom_range(0, 149) == 0);
      bus.miss_detected = ($urandom_range(0, 7) == 0);
      bus.hit           = 1'($urandom);
      bus.hit_way       = 1'($urandom);
      bus.miss_address  = 16'($urandom);
      bus.block0_isLRU  = 1'($urandom);
      bus.block1_isLRU  = 1'($urandom);
      stray_valid       = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 20; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
